// File: rtl/e203_rf_pkg.sv
// Shared definitions for the EXU general-purpose register file.
// - rf_idx_width(): index width for a given register count (minimum 1 bit)
// - default data width / register count for the RV32I configuration
// - rf_idx_t / rf_dat_t: index and data types for the default configuration
package e203_rf_pkg;

    localparam int RF_XLEN_DEF    = 32;
    localparam int RF_REG_NUM_DEF = 32;

    function automatic int rf_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RF_IDX_W_DEF = rf_idx_width(RF_REG_NUM_DEF);

    typedef logic [RF_IDX_W_DEF-1:0] rf_idx_t;
    typedef logic [RF_XLEN_DEF-1:0]  rf_dat_t;

endpackage

// File: rtl/e203_rf_rdport.sv
// One register-file read port: index mux over the stored registers, optional
// same-cycle write-back bypass, and pending qualification.
// Ports:
//   rd_idx   register index read by this port
//   regs     registered contents of all registers
//   pend     pending bit per register
//   wr_en/wr_idx/wr_dat  write-back ports (flattened), used for bypass
//   rd_dat   read data (combinational)
//   rd_busy  read register has an outstanding producer not satisfied by bypass
module e203_rf_rdport
    import e203_rf_pkg::*;
#(
    parameter int XLEN      = RF_XLEN_DEF,
    parameter int RFREG_NUM = RF_REG_NUM_DEF,
    parameter int RFIDX_W   = rf_idx_width(RFREG_NUM),
    parameter int NWR       = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 1
)(
    input  logic [RFIDX_W-1:0]                rd_idx,
    input  logic [RFREG_NUM-1:0][XLEN-1:0]    regs,
    input  logic [RFREG_NUM-1:0]              pend,
    input  logic [NWR-1:0]                    wr_en,
    input  logic [NWR*RFIDX_W-1:0]            wr_idx,
    input  logic [NWR*XLEN-1:0]               wr_dat,
    output logic [XLEN-1:0]                   rd_dat,
    output logic                              rd_busy
);

    logic [XLEN-1:0] stored;
    logic [XLEN-1:0] byp_dat;
    logic            pend_sel;
    logic            in_range;
    logic            byp_hit;

    always_comb begin
        stored   = '0;
        pend_sel = 1'b0;
        in_range = 1'b0;
        // Explicit compare loop so out-of-range indices (non power-of-two
        // register counts) read as zero and never pending.
        for (int r = 0; r < RFREG_NUM; r++) begin
            if (rd_idx == RFIDX_W'(r)) begin
                stored   = regs[r];
                pend_sel = pend[r];
                in_range = 1'b1;
            end
        end

        // Later ports override earlier ones: highest write port wins.
        byp_hit = 1'b0;
        byp_dat = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_idx[w*RFIDX_W +: RFIDX_W] == rd_idx)) begin
                byp_hit = 1'b1;
                byp_dat = wr_dat[w*XLEN +: XLEN];
            end
        end
        // Writes that the storage drops must not be forwarded either.
        if (!in_range || ((ZERO_REG != 0) && (rd_idx == '0)) || (BYPASS == 0))
            byp_hit = 1'b0;
    end

    assign rd_dat  = byp_hit ? byp_dat : stored;
    assign rd_busy = pend_sel & ~byp_hit;

endmodule

// File: rtl/e203_exu_regfile_mp.sv
// Multi-port general-purpose register file for the EXU with per-register
// pending (scoreboard) bits.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   rd_idx/rd_dat     NRD read ports (flattened), combinational data
//   rd_busy           per read port: register has an outstanding producer
//   wr_en/wr_idx/wr_dat  NWR write-back ports, higher index has priority
//   iss_en/iss_idx    dispatch marks a destination register pending
//   busy_vec          registered pending bit per register
//   x1_r              registered x1 (return address) for the branch predictor
module e203_exu_regfile_mp
    import e203_rf_pkg::*;
#(
    parameter int XLEN      = RF_XLEN_DEF,
    parameter int RFREG_NUM = RF_REG_NUM_DEF,
    parameter int NRD       = 2,
    parameter int NWR       = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 1,
    localparam int RFIDX_W  = rf_idx_width(RFREG_NUM)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*RFIDX_W-1:0]  rd_idx,
    output logic [NRD*XLEN-1:0]     rd_dat,
    output logic [NRD-1:0]          rd_busy,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR*RFIDX_W-1:0]  wr_idx,
    input  logic [NWR*XLEN-1:0]     wr_dat,
    input  logic                    iss_en,
    input  logic [RFIDX_W-1:0]      iss_idx,
    output logic [RFREG_NUM-1:0]    busy_vec,
    output logic [XLEN-1:0]         x1_r
);

    logic [RFREG_NUM-1:0][XLEN-1:0] regs;
    logic [RFREG_NUM-1:0]           pend;

    for (genvar r = 0; r < RFREG_NUM; r++) begin : g_reg
        if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
            assign regs[r] = '0;
            assign pend[r] = 1'b0;
        end else begin : g_gpr
            logic            wr_hit;
            logic [XLEN-1:0] wr_sel;
            logic [XLEN-1:0] dat_q;
            logic            pend_q;

            always_comb begin
                wr_hit = 1'b0;
                wr_sel = '0;
                for (int w = 0; w < NWR; w++) begin
                    if (wr_en[w] && (wr_idx[w*RFIDX_W +: RFIDX_W] == RFIDX_W'(r))) begin
                        wr_hit = 1'b1;
                        wr_sel = wr_dat[w*XLEN +: XLEN];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    dat_q  <= '0;
                    pend_q <= 1'b0;
                end else begin
                    if (wr_hit)
                        dat_q <= wr_sel;
                    // A new issue outranks a completing write-back: the
                    // newer producer is still outstanding.
                    if (iss_en && (iss_idx == RFIDX_W'(r)))
                        pend_q <= 1'b1;
                    else if (wr_hit)
                        pend_q <= 1'b0;
                end
            end

            assign regs[r] = dat_q;
            assign pend[r] = pend_q;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        e203_rf_rdport #(
            .XLEN      (XLEN),
            .RFREG_NUM (RFREG_NUM),
            .RFIDX_W   (RFIDX_W),
            .NWR       (NWR),
            .BYPASS    (BYPASS),
            .ZERO_REG  (ZERO_REG)
        ) u_rdport (
            .rd_idx  (rd_idx[p*RFIDX_W +: RFIDX_W]),
            .regs    (regs),
            .pend    (pend),
            .wr_en   (wr_en),
            .wr_idx  (wr_idx),
            .wr_dat  (wr_dat),
            .rd_dat  (rd_dat[p*XLEN +: XLEN]),
            .rd_busy (rd_busy[p])
        );
    end

    assign busy_vec = pend;
    assign x1_r     = regs[1];

endmodule

// File: tb/tb_e203_exu_regfile_mp.sv
module tb_e203_exu_regfile_mp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default configuration (BYPASS=1)
    logic [9:0]  m_rd_idx;
    logic [63:0] m_rd_dat;
    logic [1:0]  m_rd_busy;
    logic [1:0]  m_wr_en;
    logic [9:0]  m_wr_idx;
    logic [63:0] m_wr_dat;
    logic        m_iss_en;
    logic [4:0]  m_iss_idx;
    logic [31:0] m_busy_vec;
    logic [31:0] m_x1_r;

    // BYPASS=0 configuration
    logic [9:0]  n_rd_idx;
    logic [63:0] n_rd_dat;
    logic [1:0]  n_rd_busy;
    logic [1:0]  n_wr_en;
    logic [9:0]  n_wr_idx;
    logic [63:0] n_wr_dat;
    logic        n_iss_en;
    logic [4:0]  n_iss_idx;
    logic [31:0] n_busy_vec;
    logic [31:0] n_x1_r;

    // RV32E configuration
    logic [11:0] e_rd_idx;
    logic [95:0] e_rd_dat;
    logic [2:0]  e_rd_busy;
    logic [0:0]  e_wr_en;
    logic [3:0]  e_wr_idx;
    logic [31:0] e_wr_dat;
    logic        e_iss_en;
    logic [3:0]  e_iss_idx;
    logic [15:0] e_busy_vec;
    logic [31:0] e_x1_r;

    int pass_cnt = 0;
    int total_cnt = 0;

    e203_exu_regfile_mp #(.BYPASS(1)) u_main (
        .clk(clk), .rst(rst),
        .rd_idx(m_rd_idx), .rd_dat(m_rd_dat), .rd_busy(m_rd_busy),
        .wr_en(m_wr_en), .wr_idx(m_wr_idx), .wr_dat(m_wr_dat),
        .iss_en(m_iss_en), .iss_idx(m_iss_idx),
        .busy_vec(m_busy_vec), .x1_r(m_x1_r)
    );

    e203_exu_regfile_mp #(.BYPASS(0)) u_nobyp (
        .clk(clk), .rst(rst),
        .rd_idx(n_rd_idx), .rd_dat(n_rd_dat), .rd_busy(n_rd_busy),
        .wr_en(n_wr_en), .wr_idx(n_wr_idx), .wr_dat(n_wr_dat),
        .iss_en(n_iss_en), .iss_idx(n_iss_idx),
        .busy_vec(n_busy_vec), .x1_r(n_x1_r)
    );

    e203_exu_regfile_mp #(.RFREG_NUM(16), .NRD(3), .NWR(1)) u_rve (
        .clk(clk), .rst(rst),
        .rd_idx(e_rd_idx), .rd_dat(e_rd_dat), .rd_busy(e_rd_busy),
        .wr_en(e_wr_en), .wr_idx(e_wr_idx), .wr_dat(e_wr_dat),
        .iss_en(e_iss_en), .iss_idx(e_iss_idx),
        .busy_vec(e_busy_vec), .x1_r(e_x1_r)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_wr_en = '0; m_iss_en = 1'b0;
        n_wr_en = '0; n_iss_en = 1'b0;
        e_wr_en = '0; e_iss_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        m_rd_idx = {5'd1, 5'd5}; n_rd_idx = '0; e_rd_idx = '0;
        m_wr_idx = '0; m_wr_dat = '0; m_iss_idx = '0;
        n_wr_idx = '0; n_wr_dat = '0; n_iss_idx = '0;
        e_wr_idx = '0; e_wr_dat = '0; e_iss_idx = '0;
        step(); step();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (m_rd_dat !== 64'h0) $display("FAIL reset_rd_dat got=%h exp=0", m_rd_dat); else pass_cnt++;
        total_cnt++;
        if (m_busy_vec !== 32'h0 || m_rd_busy !== 2'b00)
            $display("FAIL reset_busy got=%h/%b exp=0/00", m_busy_vec, m_rd_busy);
        else pass_cnt++;
        total_cnt++;
        if (m_x1_r !== 32'h0) $display("FAIL reset_x1 got=%h exp=0", m_x1_r); else pass_cnt++;

        // x5 = DEADBEEF, also mark x5 pending
        m_wr_en = 2'b01; m_wr_idx = {5'd0, 5'd5}; m_wr_dat = {32'h0, 32'hDEAD_BEEF};
        step();
        idle();
        m_iss_en = 1'b1; m_iss_idx = 5'd5;
        step();
        idle();
        #1;
        total_cnt++;
        if (m_rd_dat[31:0] !== 32'hDEAD_BEEF || m_busy_vec !== 32'h0000_0020)
            $display("FAIL pre_reset_x5 got=%h/%h exp=deadbeef/00000020", m_rd_dat[31:0], m_busy_vec);
        else pass_cnt++;

        // reset wins over same-cycle write and issue
        rst = 1'b1;
        m_wr_en = 2'b01; m_wr_dat = {32'h0, 32'h0000_1234};
        m_iss_en = 1'b1; m_iss_idx = 5'd5;
        step();
        rst = 1'b0;
        idle();
        #1;
        total_cnt++;
        if (m_rd_dat[31:0] !== 32'h0) $display("FAIL reset_dominates_wr got=%h exp=0", m_rd_dat[31:0]); else pass_cnt++;
        total_cnt++;
        if (m_busy_vec !== 32'h0) $display("FAIL reset_dominates_iss got=%h exp=0", m_busy_vec); else pass_cnt++;
    endtask

    task automatic test_collision();
        m_wr_en = 2'b11;
        m_wr_idx = {5'd7, 5'd7};
        m_wr_dat = {32'h0000_2222, 32'h0000_1111};
        m_rd_idx = {5'd7, 5'd7};
        #1;
        total_cnt++;
        if (m_rd_dat !== {32'h0000_2222, 32'h0000_2222})
            $display("FAIL collision_bypass got=%h exp=0000222200002222", m_rd_dat);
        else pass_cnt++;
        step();
        // different registers on the two ports in one cycle
        m_wr_en = 2'b11;
        m_wr_idx = {5'd12, 5'd11};
        m_wr_dat = {32'h0000_CCCC, 32'h0000_BBBB};
        step();
        idle();
        m_rd_idx = {5'd11, 5'd7};
        #1;
        total_cnt++;
        if (m_rd_dat !== {32'h0000_BBBB, 32'h0000_2222})
            $display("FAIL collision_stored got=%h exp=0000bbbb00002222", m_rd_dat);
        else pass_cnt++;
        m_rd_idx = {5'd0, 5'd12};
        #1;
        total_cnt++;
        if (m_rd_dat[31:0] !== 32'h0000_CCCC)
            $display("FAIL dual_port_write got=%h exp=0000cccc", m_rd_dat[31:0]);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        m_wr_en = 2'b01; m_wr_idx = {5'd0, 5'd3}; m_wr_dat = {32'h0, 32'h0000_0F0F};
        n_wr_en = 2'b01; n_wr_idx = {5'd0, 5'd3}; n_wr_dat = {32'h0, 32'h0000_0F0F};
        step();
        idle();
        m_iss_en = 1'b1; m_iss_idx = 5'd3;
        n_iss_en = 1'b1; n_iss_idx = 5'd3;
        step();
        idle();
        m_rd_idx = {5'd3, 5'd3};
        n_rd_idx = {5'd3, 5'd3};
        #1;
        total_cnt++;
        if (m_rd_busy !== 2'b11) $display("FAIL pending_rd_busy got=%b exp=11", m_rd_busy); else pass_cnt++;

        // write-back through port 1 while reading
        m_wr_en = 2'b10; m_wr_idx = {5'd3, 5'd0}; m_wr_dat = {32'h0000_A5A5, 32'h0};
        n_wr_en = 2'b10; n_wr_idx = {5'd3, 5'd0}; n_wr_dat = {32'h0000_A5A5, 32'h0};
        #1;
        total_cnt++;
        if (m_rd_dat !== {32'h0000_A5A5, 32'h0000_A5A5} || m_rd_busy !== 2'b00)
            $display("FAIL bypass_on got=%h/%b exp=0000a5a50000a5a5/00", m_rd_dat, m_rd_busy);
        else pass_cnt++;
        total_cnt++;
        if (n_rd_dat !== {32'h0000_0F0F, 32'h0000_0F0F} || n_rd_busy !== 2'b11)
            $display("FAIL bypass_off got=%h/%b exp=00000f0f00000f0f/11", n_rd_dat, n_rd_busy);
        else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++;
        if (n_rd_dat[31:0] !== 32'h0000_A5A5 || n_busy_vec !== 32'h0 || m_busy_vec !== 32'h0)
            $display("FAIL bypass_after got=%h/%h/%h exp=0000a5a5/0/0", n_rd_dat[31:0], n_busy_vec, m_busy_vec);
        else pass_cnt++;
    endtask

    task automatic test_scoreboard();
        m_iss_en = 1'b1; m_iss_idx = 5'd9;
        #1;
        total_cnt++;
        if (m_busy_vec !== 32'h0) $display("FAIL iss_latency got=%h exp=0", m_busy_vec); else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++;
        if (m_busy_vec !== 32'h0000_0200) $display("FAIL iss_set got=%h exp=00000200", m_busy_vec); else pass_cnt++;
        m_wr_en = 2'b01; m_wr_idx = {5'd0, 5'd9}; m_wr_dat = {32'h0, 32'h0000_0099};
        step();
        idle();
        #1;
        total_cnt++;
        if (m_busy_vec !== 32'h0) $display("FAIL wr_clear got=%h exp=0", m_busy_vec); else pass_cnt++;
        m_iss_en = 1'b1; m_iss_idx = 5'd9;
        step();
        m_wr_en = 2'b01; m_wr_idx = {5'd0, 5'd9}; m_wr_dat = {32'h0, 32'h0000_0077};
        step();
        idle();
        m_rd_idx = {5'd0, 5'd9};
        #1;
        total_cnt++;
        if (m_busy_vec !== 32'h0000_0200 || m_rd_dat[31:0] !== 32'h0000_0077 || m_rd_busy[0] !== 1'b1)
            $display("FAIL iss_wr_same got=%h/%h/%b exp=00000200/00000077/1",
                     m_busy_vec, m_rd_dat[31:0], m_rd_busy[0]);
        else pass_cnt++;
        // leave scoreboard clean
        m_wr_en = 2'b01;
        step();
        idle();
    endtask

    task automatic test_x0();
        m_wr_en = 2'b11; m_wr_idx = {5'd0, 5'd0}; m_wr_dat = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        m_iss_en = 1'b1; m_iss_idx = 5'd0;
        m_rd_idx = {5'd0, 5'd0};
        #1;
        total_cnt++;
        if (m_rd_dat !== 64'h0 || m_rd_busy !== 2'b00)
            $display("FAIL x0_bypass got=%h/%b exp=0/00", m_rd_dat, m_rd_busy);
        else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++;
        if (m_rd_dat !== 64'h0 || m_busy_vec !== 32'h0)
            $display("FAIL x0_stored got=%h/%h exp=0/0", m_rd_dat, m_busy_vec);
        else pass_cnt++;
    endtask

    task automatic test_rv32e();
        e_wr_en = 1'b1; e_wr_idx = 4'd15; e_wr_dat = 32'h0000_0005;
        step();
        idle();
        e_rd_idx = {4'd15, 4'd15, 4'd15};
        #1;
        total_cnt++;
        if (e_rd_dat !== {32'h5, 32'h5, 32'h5} || e_rd_busy !== 3'b000)
            $display("FAIL rve_x15 got=%h/%b exp=000000050000000500000005/000", e_rd_dat, e_rd_busy);
        else pass_cnt++;
        e_wr_en = 1'b1; e_wr_idx = 4'd1; e_wr_dat = 32'h8000_0100;
        #1;
        total_cnt++;
        if (e_x1_r !== 32'h0) $display("FAIL rve_x1_early got=%h exp=0", e_x1_r); else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++;
        if (e_x1_r !== 32'h8000_0100) $display("FAIL rve_x1 got=%h exp=80000100", e_x1_r); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        m_wr_en = 2'b01; m_wr_idx = {5'd0, 5'd1}; m_wr_dat = {32'h0, 32'h0000_1000};
        step();
        m_wr_en = 2'b10; m_wr_idx = {5'd1, 5'd0}; m_wr_dat = {32'h0000_2000, 32'h0};
        m_rd_idx = {5'd0, 5'd1};
        #1;
        total_cnt++;
        if (m_x1_r !== 32'h0000_1000 || m_rd_dat[31:0] !== 32'h0000_2000)
            $display("FAIL b2b_first got=%h/%h exp=00001000/00002000", m_x1_r, m_rd_dat[31:0]);
        else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++;
        if (m_x1_r !== 32'h0000_2000) $display("FAIL b2b_second got=%h exp=00002000", m_x1_r); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_x0();
        test_rv32e();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
